// File: rtl/key_pkg.sv
// key_pkg: shared key indices, direction codes and debouncer state encoding
package key_pkg;
  localparam int KEY_UP = 0;
  localparam int KEY_DOWN = 1;
  localparam int KEY_LEFT = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_SWITCH = 4;
  localparam int NUM_KEYS = 5;
  localparam int CNT_W = 20;
  localparam logic [1:0] DIR_UP = 2'd0;
  localparam logic [1:0] DIR_DOWN = 2'd1;
  localparam logic [1:0] DIR_LEFT = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;
  // bit 1 of the encoding is the debounced level
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } deb_state_e;
  // up > down > left > right; right wins only when nothing above it pressed
  function automatic logic [1:0] prio_dir(input logic [2:0] p);
    return p[KEY_UP] ? DIR_UP : p[KEY_DOWN] ? DIR_DOWN : p[KEY_LEFT] ? DIR_LEFT : DIR_RIGHT;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizer, debounce FSM and press pulse for one key
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  logic sync;
  deb_state_e state;
  logic [CNT_W-1:0] count;
  assign sync = sync_q[1];
  assign level = state[1];
  // two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= 2'b00;
    else sync_q <= {sync_q[0], raw};
  // accept a level change only after DEBOUNCE_CYCLES consecutive agreeing samples
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= STABLE_LOW;
      count <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        STABLE_LOW:
          if (sync) begin
            state <= WAIT_HIGH;
            count <= CNT_W'(1);
          end
        WAIT_HIGH:
          if (!sync) begin
            state <= STABLE_LOW;
            count <= '0;
          end else if (count == LAST) begin
            state <= STABLE_HIGH;
            count <= '0;
            press <= 1'b1;
          end else count <= count + CNT_W'(1);
        STABLE_HIGH:
          if (!sync) begin
            state <= WAIT_LOW;
            count <= CNT_W'(1);
          end
        WAIT_LOW:
          if (sync) begin
            state <= STABLE_HIGH;
            count <= '0;
          end else if (count == LAST) begin
            state <= STABLE_LOW;
            count <= '0;
          end else count <= count + CNT_W'(1);
      endcase
    end
endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: debounced key events with direction priority and hold gating
module key_event_gen
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] key_raw,
  input  logic       hold,
  output logic       key_switch,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [4:0] key_level
);
  logic [NUM_KEYS-1:0] press;
  logic dir_hit;
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (key_raw[i]),
      .level(key_level[i]),
      .press(press[i])
    );
  end
  assign dir_hit = |press[KEY_RIGHT:KEY_UP] && !hold;
  // register event pulses; losing and held-off directions are simply dropped
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      key_switch <= 1'b0;
      move_valid <= 1'b0;
      move_dir <= DIR_UP;
    end else begin
      key_switch <= press[KEY_SWITCH];
      move_valid <= dir_hit;
      if (dir_hit) move_dir <= prio_dir(press[KEY_LEFT:KEY_UP]);
    end
endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: scenario tasks plus random stimulus against a window-based reference model
module tb_key_event_gen;
  localparam int DEB = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] key_raw = '0;
  logic hold = 1'b0;
  logic key_switch, move_valid;
  logic [1:0] move_dir;
  logic [4:0] key_level;
  int checks = 0, errors = 0;

  key_event_gen #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .key_raw(key_raw), .hold(hold),
    .key_switch(key_switch), .move_valid(move_valid), .move_dir(move_dir), .key_level(key_level)
  );

  always #5 clk = ~clk;

  // reference model: level flips when the last DEB synchronized samples all disagree with it
  logic [4:0] m_s1, m_s2, m_lvl, m_pend, m_flip;
  logic [4:0] m_hist [DEB-1];
  logic m_sw, m_mv;
  logic [1:0] m_dir, m_first;
  always_comb begin
    m_flip = '1;
    for (int k = 0; k < 5; k++) begin
      if (m_s2[k] == m_lvl[k]) m_flip[k] = 1'b0;
      for (int j = 0; j < DEB - 1; j++) if (m_hist[j][k] == m_lvl[k]) m_flip[k] = 1'b0;
    end
    m_first = 2'd0;
    for (int k = 3; k >= 0; k--) if (m_pend[k]) m_first = 2'(k);
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_pend <= '0;
      m_sw <= 1'b0; m_mv <= 1'b0; m_dir <= 2'd0;
      for (int j = 0; j < DEB - 1; j++) m_hist[j] <= '0;
    end else begin
      m_sw <= m_pend[4];
      m_mv <= |m_pend[3:0] && !hold;
      if (|m_pend[3:0] && !hold) m_dir <= m_first;
      m_pend <= m_flip & ~m_lvl;
      m_lvl <= m_lvl ^ m_flip;
      m_hist[0] <= m_s2;
      for (int j = 1; j < DEB - 1; j++) m_hist[j] <= m_hist[j-1];
      m_s2 <= m_s1;
      m_s1 <= key_raw;
    end
  end

  // monitor: pulse counts, timing and lockstep disagreement with the model
  int cyc = 0, sw_cnt = 0, mv_cnt = 0, m_sw_cnt = 0, m_mv_cnt = 0, mism = 0, lvl0_hi = 0;
  int last_sw_cyc = 0, last_mv_cyc = 0;
  logic [1:0] last_dir = 2'd0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (key_switch) begin sw_cnt <= sw_cnt + 1; last_sw_cyc <= cyc; end
    if (move_valid) begin mv_cnt <= mv_cnt + 1; last_mv_cyc <= cyc; last_dir <= move_dir; end
    if (m_sw) m_sw_cnt <= m_sw_cnt + 1;
    if (m_mv) m_mv_cnt <= m_mv_cnt + 1;
    if (key_level[0]) lvl0_hi <= lvl0_hi + 1;
    if ({key_switch, move_valid, move_dir, key_level} !== {m_sw, m_mv, m_dir, m_lvl}) mism <= mism + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    key_raw = 5'h1f;
    idle(3);
    checks += 4;
    if (key_switch !== 1'b0) begin errors++; $display("FAIL reset_switch: got %b expected 0", key_switch); end
    if (move_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", move_valid); end
    if (move_dir !== 2'd0) begin errors++; $display("FAIL reset_dir: got %0d expected 0", move_dir); end
    if (key_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %b expected 00000", key_level); end
    key_raw = '0;
    idle(1);
    reset = 1'b0;
    idle(4);
  endtask

  task automatic test_glitch;
    int mv0 = mv_cnt, mm0 = mism, l0 = lvl0_hi;
    @(negedge clk) key_raw = 5'b00001;
    repeat (3) @(negedge clk);
    key_raw = '0;
    idle(12);
    checks += 3;
    if (mv_cnt - mv0 != 0) begin errors++; $display("FAIL glitch_events: got %0d expected 0", mv_cnt - mv0); end
    if (lvl0_hi != l0) begin errors++; $display("FAIL glitch_level: got %0d high cycles expected 0", lvl0_hi - l0); end
    if (mism != mm0) begin errors++; $display("FAIL glitch_model: got %0d disagreeing cycles expected 0", mism - mm0); end
  endtask

  task automatic test_single;
    int mv0 = mv_cnt, mm0 = mism, base;
    @(negedge clk) key_raw = 5'b00100;
    base = cyc;
    idle(20);
    checks += 4;
    if (mv_cnt - mv0 != 1) begin errors++; $display("FAIL single_events: got %0d expected 1", mv_cnt - mv0); end
    if (last_dir !== 2'd2) begin errors++; $display("FAIL single_dir: got %0d expected 2", last_dir); end
    if (last_mv_cyc - base != DEB + 3) begin errors++; $display("FAIL single_latency: got %0d expected %0d", last_mv_cyc - base, DEB + 3); end
    if (key_level[2] !== 1'b1) begin errors++; $display("FAIL single_level: got %b expected 1", key_level[2]); end
    key_raw = '0;
    idle(12);
    checks++;
    if (mism != mm0) begin errors++; $display("FAIL single_model: got %0d disagreeing cycles expected 0", mism - mm0); end
  endtask

  task automatic test_simultaneous;
    int mv0 = mv_cnt;
    @(negedge clk) key_raw = 5'b01001;
    idle(20);
    checks += 2;
    if (mv_cnt - mv0 != 1) begin errors++; $display("FAIL simul_events: got %0d expected 1", mv_cnt - mv0); end
    if (last_dir !== 2'd0) begin errors++; $display("FAIL simul_dir: got %0d expected 0", last_dir); end
    key_raw = '0;
    idle(12);
    checks++;
    if (mv_cnt - mv0 != 1) begin errors++; $display("FAIL simul_late: got %0d events expected 1", mv_cnt - mv0); end
  endtask

  task automatic test_hold;
    int mv0 = mv_cnt, sw0 = sw_cnt, base;
    @(negedge clk) key_raw = 5'b10010;
    base = cyc;
    repeat (DEB + 2) @(negedge clk);
    hold = 1'b1;
    @(negedge clk) hold = 1'b0;
    idle(12);
    checks += 3;
    if (sw_cnt - sw0 != 1) begin errors++; $display("FAIL hold_switch: got %0d expected 1", sw_cnt - sw0); end
    if (last_sw_cyc - base != DEB + 3) begin errors++; $display("FAIL hold_switch_time: got %0d expected %0d", last_sw_cyc - base, DEB + 3); end
    if (mv_cnt - mv0 != 0) begin errors++; $display("FAIL hold_move: got %0d expected 0", mv_cnt - mv0); end
    key_raw = '0;
    idle(12);
  endtask

  task automatic test_reset_mid;
    int sw0 = sw_cnt, base;
    @(negedge clk) key_raw = 5'b10000;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sw_cnt - sw0 != 0) begin errors++; $display("FAIL rmid_early: got %0d expected 0", sw_cnt - sw0); end
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    base = cyc;
    idle(15);
    checks += 2;
    if (sw_cnt - sw0 != 1) begin errors++; $display("FAIL rmid_events: got %0d expected 1", sw_cnt - sw0); end
    if (last_sw_cyc - base != DEB + 3) begin errors++; $display("FAIL rmid_time: got %0d expected %0d", last_sw_cyc - base, DEB + 3); end
    key_raw = '0;
    idle(12);
  endtask

  task automatic test_back_to_back;
    int mv0 = mv_cnt;
    @(negedge clk) key_raw = 5'b01000;
    idle(20);
    key_raw = '0;
    idle(10);
    key_raw = 5'b01000;
    idle(20);
    key_raw = '0;
    idle(12);
    checks += 2;
    if (mv_cnt - mv0 != 2) begin errors++; $display("FAIL b2b_long: got %0d expected 2", mv_cnt - mv0); end
    if (last_dir !== 2'd3) begin errors++; $display("FAIL b2b_dir: got %0d expected 3", last_dir); end
    mv0 = mv_cnt;
    key_raw = 5'b01000;
    idle(20);
    key_raw = '0;
    idle(2);
    key_raw = 5'b01000;
    idle(20);
    key_raw = '0;
    idle(12);
    checks++;
    if (mv_cnt - mv0 != 1) begin errors++; $display("FAIL b2b_short: got %0d expected 1", mv_cnt - mv0); end
  endtask

  task automatic test_random;
    int sw0 = sw_cnt, mv0 = mv_cnt, msw0 = m_sw_cnt, mmv0 = m_mv_cnt, mm0 = mism;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      key_raw = 5'($urandom_range(0, 31));
      hold = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    key_raw = '0;
    hold = 1'b0;
    idle(12);
    checks += 3;
    if (sw_cnt - sw0 != m_sw_cnt - msw0) begin errors++; $display("FAIL rand_switch: got %0d expected %0d", sw_cnt - sw0, m_sw_cnt - msw0); end
    if (mv_cnt - mv0 != m_mv_cnt - mmv0) begin errors++; $display("FAIL rand_move: got %0d expected %0d", mv_cnt - mv0, m_mv_cnt - mmv0); end
    if (mism != mm0) begin errors++; $display("FAIL rand_model: got %0d disagreeing cycles expected 0", mism - mm0); end
  endtask

  initial begin
    #2;
    test_reset;
    test_glitch;
    test_single;
    test_simultaneous;
    test_hold;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
